instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Encodes instruction descriptors (format, register indices, funct3, 32-bit signed immediate) into 32-bit RV32I instruction words. It is the inverse of the immediate generator.
- Used by the instruction-memory loader and the self-check bench to produce instruction streams, each tagged with a sequential word address.
- Valid/ready on both sides, one output register, immediate range and alignment checking, running error count.

Parameters:
- ADDR_WIDTH, 32, width of out_addr.
- BASE_ADDR, 0, address assigned to the first word after reset or clear; must be 4-byte aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart: flush the output register and rewind the address.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  encoder can accept a descriptor this cycle.
- in_fmt  input  3  0=I-ALU(0010011), 1=LOAD(0000011), 2=STORE(0100011), 3=BRANCH(1100011), 4=JAL(1101111), 5-7 illegal.
- in_rd  input  5  destination register; ignored for STORE and BRANCH.
- in_rs1  input  5  source 1; ignored for JAL.
- in_rs2  input  5  source 2; STORE and BRANCH only.
- in_funct3  input  3  funct3 field; ignored for JAL.
- in_imm  input  32  signed byte-offset immediate.
- out_valid  output  1  out_instr, out_addr and out_err are valid.
- out_ready  input  1  consumer accepts the output.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_WIDTH  word address of out_instr.
- out_err  output  1  descriptor was rejected; out_instr is the NOP.
- err_count  output  16  saturating count of rejected descriptors.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_count=0.
  - Internal next-address register = BASE_ADDR.
- Handshake:
  - in_ready = !clear && (!out_valid || out_ready).
  - Acceptance = in_valid && in_ready. Latency 1: the encoded word is in the output register on the next edge.
  - The output holds stable while out_valid && !out_ready.
  - Simultaneous drain and accept (out_valid && out_ready && in_valid) sustains full throughput: 1 word per cycle.
  - Drain without accept clears out_valid.
- Address:
  - On acceptance: out_addr <= next_addr, then next_addr <= next_addr + 4.
  - Wraps modulo 2^ADDR_WIDTH with no flag.
- Packing (standard RV32I bit placement):
  - I/LOAD: imm[11:0] in bits [31:20].
  - STORE: imm[11:5] in [31:25], imm[4:0] in [11:7].
  - BRANCH: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7].
  - JAL: imm[20|10:1|11|19:12] in [31:12].
- Legality (in_imm read as two's complement):
  - I/LOAD/STORE: -2048..2047.
  - BRANCH: -4096..4094 and imm[0]=0.
  - JAL: -1048576..1048574 and imm[0]=0.
  - in_fmt 5-7 is always illegal.
- Illegal descriptor:
  - out_instr = 32'h00000013 (addi x0,x0,0), out_err=1.
  - The address is still consumed.
  - err_count increments on acceptance and saturates at 16'hFFFF.
- Round-trip property: for every legal descriptor, decoding out_instr with the immediate generator returns in_imm exactly.
- clear:
  - Priority over everything: out_valid <= 0, out_err <= 0, next_addr <= BASE_ADDR, out_addr <= BASE_ADDR.
  - err_count is kept. No acceptance occurs in a clear cycle.
- rst_n asserted mid-stream: the pending output is lost immediately, and out_valid falls asynchronously.

Test Plan:
- Reset, then I-ALU rd=1 rs1=0 f3=0 imm=5, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0, out_err=0.
- Back-to-back LOAD rd=2 rs1=3 f3=2 imm=8, then STORE rs1=6 rs2=5 f3=2 imm=-4 -> 0x0081A103 @0, then 0xFE532E23 @4, with no bubble.
- BRANCH rs1=1 rs2=2 f3=0 imm=8 -> 0x00208463; JAL rd=1 imm=2048 -> 0x001000EF; decoding each with the immediate generator returns the same imm.
- I-ALU imm=2048, BRANCH imm=3, in_fmt=6 -> each produces out_instr=0x00000013 with out_err=1; err_count=3; addresses 0, 4, 8 are still consumed.
- out_ready=0 with two descriptors offered -> first held stable and in_ready=0 for the second; raising out_ready drains the first and accepts the second in the same cycle.
- clear asserted while out_valid=1 at out_addr=0x10 -> out_valid=0 next cycle and the next accepted word gets out_addr=BASE_ADDR; err_count unchanged. Then rst_n pulsed mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs format/register/immediate descriptors
// into instruction words tagged with a sequential word address.
module instr_encoder #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_fmt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [31:0]           in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_err,
    output logic [15:0]           err_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    logic is_i, is_ld, is_st, is_br, is_jal;
    logic fits12, fits13, fits21;
    logic legal;
    logic accept;
    logic [31:0] enc;

    logic                  valid_q, valid_d;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] next_q, next_d;
    logic                  err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;

    assign is_i   = (in_fmt == 3'd0);
    assign is_ld  = (in_fmt == 3'd1);
    assign is_st  = (in_fmt == 3'd2);
    assign is_br  = (in_fmt == 3'd3);
    assign is_jal = (in_fmt == 3'd4);

    // An immediate fits N bits when everything above bit N-1 is sign copies.
    assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        legal = 1'b0;
        enc   = NOP;
        unique case (1'b1)
            is_i: begin
                legal = fits12;
                enc   = {in_imm[11:0], in_rs1, in_funct3,
                         in_rd, 7'b0010011};
            end
            is_ld: begin
                legal = fits12;
                enc   = {in_imm[11:0], in_rs1, in_funct3,
                         in_rd, 7'b0000011};
            end
            is_st: begin
                legal = fits12;
                enc   = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:0], 7'b0100011};
            end
            is_br: begin
                legal = fits13 & ~in_imm[0];
                enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                         in_funct3, in_imm[4:1], in_imm[11],
                         7'b1100011};
            end
            is_jal: begin
                legal = fits21 & ~in_imm[0];
                enc   = {in_imm[20], in_imm[10:1], in_imm[11],
                         in_imm[19:12], in_rd, 7'b1101111};
            end
            default: begin
                legal = 1'b0;
                enc   = NOP;
            end
        endcase
        if (!legal) begin
            enc = NOP;
        end
    end

    assign in_ready = !clear && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        next_d  = next_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (clear) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            addr_d  = BASE_ADDR;
            next_d  = BASE_ADDR;
        end else if (accept) begin
            valid_d = 1'b1;
            instr_d = enc;
            err_d   = !legal;
            addr_d  = next_q;
            next_d  = next_q + STEP;
            if (!legal && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            addr_q  <= BASE_ADDR;
            next_q  <= BASE_ADDR;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            next_q  <= next_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign out_err   = err_q;
    assign err_count = cnt_q;

endmodule
